// File: rtl/eka_uart_tx_mmio.sv
// Memory-mapped UART transmitter: TX FIFO plus 8N1 serializer (8E1 when UART_TX_PARITY_EN is defined).
// Register reads are combinational so the single-cycle core gets load data in the same cycle.
module eka_uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        tx
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_PRESENT = 1'b1;
`else
    localparam logic PARITY_PRESENT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_q, state_d;
    logic        tx_q, tx_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] frame_div_q, frame_div_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        overflow_q, overflow_d;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];

    logic sel, wr_hit, push_req, push, pop, start_frame, fifo_full, fifo_empty;
    logic [7:0]  head;
    logic [31:0] status;
    logic unused_bits;

    assign unused_bits = ^{data_addr[1:0], mem_wr_data[31:16]};

    always_comb begin
        sel        = (data_addr[31:4] == BASE_ADDR[31:4]);
        rd_hit     = mem_rd & sel;
        wr_hit     = mem_wr & sel;
        push_req   = wr_hit && (data_addr[3:2] == 2'd0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        head       = mem_q[rptr_q];
        tx         = tx_q;
        status     = {16'h0000, 8'(count_q), 3'b000, PARITY_PRESENT, overflow_q,
                      (state_q != IDLE), fifo_empty, fifo_full};
        rd_data    = '0;
        if (rd_hit) begin
            unique case (data_addr[3:2])
                2'd1:    rd_data = status;
                2'd2:    rd_data = {16'h0000, div_q};
                default: rd_data = '0;
            endcase
        end
    end

    // Serializer: a frame start (from IDLE or end of STOP) is handled once after the case.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        baud_d      = baud_q;
        frame_div_d = frame_div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        start_frame = 1'b0;
        unique case (state_q)
            IDLE: start_frame = !fifo_empty;
            default: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - 16'd1;
                end else begin
                    baud_d = frame_div_q - 16'd1;
                    unique case (state_q)
                        START: begin
                            state_d = DATA;
                            tx_d    = shift_q[0];
                        end
                        DATA: begin
                            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state_d = PARITY;
                                tx_d    = par_q;
`else
                                state_d = STOP;
                                tx_d    = 1'b1;
`endif
                            end else begin
                                bit_d   = bit_q + 3'd1;
                                shift_d = shift_q >> 1;
                                tx_d    = shift_q[1];
                            end
                        end
                        PARITY: begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                        default: begin
                            state_d     = IDLE;
                            start_frame = !fifo_empty;
                        end
                    endcase
                end
            end
        endcase
        pop = start_frame;
        if (start_frame) begin
            state_d     = START;
            tx_d        = 1'b0;
            shift_d     = head;
            par_d       = ^head;
            bit_d       = '0;
            frame_div_d = div_q;
            baud_d      = div_q - 16'd1;
        end
    end

    always_comb begin
        push       = push_req && (!fifo_full || pop);
        overflow_d = overflow_q;
        if (wr_hit && data_addr[3:2] == 2'd1 && mem_wr_data[3]) overflow_d = 1'b0;
        if (push_req && !push) overflow_d = 1'b1;
        div_d = div_q;
        if (wr_hit && data_addr[3:2] == 2'd2)
            div_d = (mem_wr_data[15:0] == '0) ? 16'd1 : mem_wr_data[15:0];
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = mem_wr_data[7:0];
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q     <= IDLE;
            tx_q        <= 1'b1;
            baud_q      <= '0;
            frame_div_q <= DEFAULT_DIV;
            div_q       <= DEFAULT_DIV;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            overflow_q  <= 1'b0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            baud_q      <= baud_d;
            frame_div_q <= frame_div_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            overflow_q  <= overflow_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_eka_uart_tx_mmio.sv
// Scoreboard bench for eka_uart_tx_mmio: read and frame expectations are queued by stimulus,
// and independent monitors compare load data and the serial line against them.
module tb_eka_uart_tx_mmio;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_addr = '0;
    logic [31:0] mem_wr_data = '0;
    logic        mem_wr = 1'b0;
    logic        mem_rd = 1'b0;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        tx;

    int total = 0;
    int bad = 0;
    bit mon_busy = 1'b0;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam logic [31:0] PB = 32'h10;
`else
    localparam bit PAR = 1'b0;
    localparam logic [31:0] PB = 32'h0;
`endif
    localparam logic [31:0] A_TX = 32'h8000_0000;
    localparam logic [31:0] A_ST = 32'h8000_0004;
    localparam logic [31:0] A_DV = 32'h8000_0008;

    typedef struct { logic hit; logic [31:0] data; string name; } rd_t;
    typedef struct { logic [7:0] data; int unsigned div; bit contig; int unsigned limit; } frame_t;
    rd_t    rq[$];
    frame_t fq[$];

    eka_uart_tx_mmio #(
        .BASE_ADDR(32'h8000_0000),
        .FIFO_DEPTH(4),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk(clk), .reset(reset), .data_addr(data_addr), .mem_wr_data(mem_wr_data),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .rd_data(rd_data), .rd_hit(rd_hit), .tx(tx)
    );

    always #5 clk = ~clk;

    // Load-data monitor
    always @(negedge clk) begin
        if (mem_rd) begin
            rd_t e;
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: read with no expectation queued");
            end else begin
                e = rq.pop_front();
                if (rd_hit !== e.hit || rd_data !== e.data) begin
                    bad++;
                    $display("FAIL %s: got hit=%b data=%h, required hit=%b data=%h",
                             e.name, rd_hit, rd_data, e.hit, e.data);
                end
            end
        end
    end

    // Serial-line monitor: every cycle of each frame is checked against the queued byte
    initial begin
        int unsigned idle;
        idle = 0;
        forever begin
            @(negedge clk);
            if (tx !== 1'b0) begin
                idle++;
            end else if (fq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame_unexpected: tx low with no frame queued, idle=%0d", idle);
                for (int i = 0; i < 5000 && tx === 1'b0; i++) @(negedge clk);
                idle = 0;
            end else begin
                frame_t f;
                logic [10:0] bits;
                int unsigned nb, n, errk;
                bit ok;
                logic got;
                f = fq.pop_front();
                mon_busy = 1'b1;
                nb = PAR ? 11 : 10;
                bits = '1;
                bits[0] = 1'b0;
                bits[8:1] = f.data;
                if (PAR) bits[9] = ^f.data;
                n = nb * f.div;
                if (f.limit != 0 && f.limit < n) n = f.limit;
                ok = !f.contig || idle == 0;
                errk = 0;
                got = 1'b0;
                for (int unsigned k = 0; k < n; k++) begin
                    if (k > 0) @(negedge clk);
                    if (ok && tx !== bits[k / f.div]) begin
                        ok = 1'b0;
                        errk = k;
                        got = tx;
                    end
                end
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL frame_%h: idle_before=%0d contig=%0b, cycle %0d got tx=%b, required %b",
                             f.data, idle, f.contig, errk, got, bits[errk / f.div]);
                end
                idle = 0;
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        data_addr = a;
        mem_wr_data = d;
        mem_wr = 1'b1;
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic h, input logic [31:0] d, input string nm);
        rq.push_back('{h, d, nm});
        data_addr = a;
        mem_rd = 1'b1;
        @(posedge clk);
        #1;
        mem_rd = 1'b0;
    endtask

    task automatic exp_frame(input logic [7:0] d, input int unsigned div, input bit contig,
                             input int unsigned limit);
        fq.push_back('{d, div, contig, limit});
    endtask

    task automatic wait_idle(input int unsigned budget, input string nm);
        bit done;
        done = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (fq.size() == 0 && !mon_busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: frames still pending=%0d after %0d cycles, required 0",
                     nm, fq.size(), budget);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        rd(A_ST, 1'b1, 32'h2 | PB, "status_reset");
        rd(A_DV, 1'b1, 32'h364, "div_reset");
        rd(A_TX, 1'b1, 32'h0, "txdata_reads0");

        wr(A_DV, 32'd4);
        rd(A_DV, 1'b1, 32'd4, "div_4");
        exp_frame(8'hA5, 4, 1'b0, 0);
        wr(A_TX, 32'hA5);
        wait_idle(200, "a5_done");
        rd(A_ST, 1'b1, 32'h2 | PB, "status_after_a5");

        exp_frame(8'h11, 4, 1'b0, 0);
        for (int i = 2; i <= 5; i++) exp_frame(8'(8'h10 + i), 4, 1'b1, 0);
        for (int i = 1; i <= 6; i++) wr(A_TX, 32'(32'h10 + i));
        rd(A_ST, 1'b1, 32'h40D | PB, "status_overflow");
        wr(A_ST, 32'h8);
        rd(A_ST, 1'b1, 32'h405 | PB, "status_w1c");
        wait_idle(600, "burst_done");
        rd(A_ST, 1'b1, 32'h2 | PB, "status_after_burst");

        wr(A_DV, 32'h0);
        rd(A_DV, 1'b1, 32'd1, "div_zero_is_1");
        exp_frame(8'h00, 1, 1'b0, 0);
        wr(A_TX, 32'h0);
        wait_idle(100, "div1_done");

        rd(32'h8000_0010, 1'b0, 32'h0, "miss_high");
        rd(32'h7000_0004, 1'b0, 32'h0, "miss_low");
        rd(32'h8000_000C, 1'b1, 32'h0, "reserved_reads0");
        wr(32'h8000_000C, 32'hFFFF_FFFF);
        wr(32'h8000_0010, 32'h55);
        rd(A_DV, 1'b1, 32'd1, "div_unchanged");
        rd(A_ST, 1'b1, 32'h2 | PB, "status_unchanged");
        repeat (50) @(posedge clk);
        #1;

        wr(A_DV, 32'd4);
        exp_frame(8'hA5, 4, 1'b0, 10);
        wr(A_TX, 32'hA5);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(A_ST, 1'b1, 32'h2 | PB, "status_after_abort");
        rd(A_DV, 1'b1, 32'h364, "div_after_abort");
        repeat (100) @(posedge clk);
        #1;
        wait_idle(10, "abort_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
